// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//  Shared definitions for the memory-port arbiter:
//  - FSM state encoding (IDLE/BUSY/RESP)
//  - grant encoding (GNT_I/GNT_D) and memory op encoding (OP_RD/OP_WR)
//  - default address/data widths
//  - other_side(): the opposite requester of a given grant
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 28;   // block address width
  localparam int DEF_DATA_W = 128;  // cache-line width

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } op_t;

  function automatic grant_t other_side(grant_t g);
    return (g == GNT_I) ? GNT_D : GNT_I;
  endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick
//  Combinational two-way picker for the memory arbiter.
//  Ports:
//    i_req  in   I-cache request pending
//    d_req  in   D-cache request pending (read or write)
//    d_wr   in   D-cache write-back requested (wins over a D read)
//    prio   in   side that completed the most recent grant
//    grant  out  side to serve
//    op     out  memory operation for that side
//  Build option: ARB_ROUND_ROBIN_EN
//    defined   -> on a tie the side that did NOT complete the last grant wins
//    undefined -> fixed priority, the D-cache wins every tie
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   d_wr,
  input  grant_t prio,
  output grant_t grant,
  output op_t    op
);

`ifdef ARB_ROUND_ROBIN_EN
`else
  // Fixed priority never looks at the pointer.
  logic prio_unused;
  assign prio_unused = prio;
`endif

  always_comb begin
    grant = GNT_I;
    if (d_req && !i_req) begin
      grant = GNT_D;
    end else if (d_req && i_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      // prio holds the last-served side, so the opposite side is favoured.
      grant = other_side(prio);
`else
      grant = GNT_D;
`endif
    end
    // A D-side read and write-back raised together: the write-back goes first,
    // the read stays pending and is arbitrated again afterwards.
    op = (grant == GNT_D && d_wr) ? OP_WR : OP_RD;
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//  Shares the single off-chip memory port between the I-cache line-fill path
//  and the D-cache fill / write-back path. One requester is granted at a time;
//  its command is latched, memory is driven until mem_ready, then a one-cycle
//  ready pulse with the returned line goes back to the grantee.
//  Ports:
//    clk, rst                 clock, synchronous active-high reset
//    i_read, i_addr           I-cache fill request (held until i_ready)
//    i_ready, i_rdata         I-cache completion pulse and line
//    d_read, d_write, d_addr, d_wdata   D-cache fill / write-back request
//    d_ready, d_rdata         D-cache completion pulse and line
//    mem_read, mem_write      memory strobes, held until mem_ready
//    mem_addr, mem_wdata      latched command towards memory
//    mem_ready, mem_rdata     memory completion and read line
//  Build option: ARB_ROUND_ROBIN_EN (round-robin tie-break; default is fixed
//  priority with the D-cache winning ties).
//  Timing: request sampled in IDLE at edge N, strobe high from N+1, mem_ready
//  sampled at edge M, ready pulse during cycle M+1, back in IDLE after that.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state_reg;
  grant_t grant_reg;  // side owning the current transaction
  grant_t prio_reg;   // side that completed the most recent grant

  logic   d_req;
  logic   any_req;
  grant_t pick_grant;
  op_t    pick_op;

  assign d_req   = d_read | d_write;
  assign any_req = i_read | d_req;

  arb_pick u_pick (
    .i_req (i_read),
    .d_req (d_req),
    .d_wr  (d_write),
    .prio  (prio_reg),
    .grant (pick_grant),
    .op    (pick_op)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      // Also the abort path: strobes drop at once and any late mem_ready
      // lands in IDLE where it is ignored.
      state_reg <= IDLE;
      grant_reg <= GNT_I;
      prio_reg  <= GNT_I;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      i_ready   <= 1'b0;
      d_ready   <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      // Ready outputs are pulses: cleared unless set below.
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            grant_reg <= pick_grant;
            mem_addr  <= (pick_grant == GNT_D) ? d_addr : i_addr;
            if (pick_op == OP_WR) begin
              mem_wdata <= d_wdata;
            end
            mem_read  <= (pick_op == OP_RD);
            mem_write <= (pick_op == OP_WR);
            state_reg <= BUSY;
          end
        end
        BUSY: begin
          // Completes even if the requester has since dropped its request.
          if (mem_ready) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (grant_reg == GNT_D) begin
              d_rdata <= mem_rdata;
              d_ready <= 1'b1;
            end else begin
              i_rdata <= mem_rdata;
              i_ready <= 1'b1;
            end
            prio_reg  <= grant_reg;
            state_reg <= RESP;
          end
        end
        RESP: begin
          // One dead cycle lets the requester drop its line before IDLE samples.
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//  Directed scenarios followed by randomized traffic. A transaction-level
//  model (who owns memory, whether a response cycle is due) predicts every
//  output and is compared against the DUT on each falling edge.
module tb_mem_arbiter;

  localparam int AW = 28;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read, d_read, d_write, mem_ready;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic          i_ready, d_ready, mem_read, mem_write;
  logic [DW-1:0] i_rdata, d_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int tests = 0;
  int fails = 0;
  bit started = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic          e_mem_read, e_mem_write, e_i_ready, e_d_ready;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_i_rdata, e_d_rdata;
  int            owner;        // -1: memory free, 0: I-cache, 1: D-cache
  bit            resp_due;     // the cycle after completion is the response cycle
  int            last_side;    // side that completed the latest transaction
  int            s;

  function automatic int favour_side(input int last);
`ifdef ARB_ROUND_ROBIN_EN
    return (last == 0) ? 1 : 0;
`else
    return (last >= 0) ? 1 : 1;
`endif
  endfunction

  function automatic int pick(input bit iq, input bit dq, input int fav);
    if (iq && !dq) return 0;
    if (dq && !iq) return 1;
    return fav;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      e_mem_read <= 0; e_mem_write <= 0; e_i_ready <= 0; e_d_ready <= 0;
      e_addr <= '0; e_wdata <= '0; e_i_rdata <= '0; e_d_rdata <= '0;
      owner <= -1; resp_due <= 0; last_side <= 0;
    end else begin
      e_i_ready <= 0;
      e_d_ready <= 0;
      if (resp_due) begin
        resp_due <= 0;
      end else if (owner < 0) begin
        if (i_read || d_read || d_write) begin
          s = pick(i_read, d_read | d_write, favour_side(last_side));
          owner <= s;
          if (s == 1) begin
            e_addr <= d_addr;
            if (d_write) begin
              e_mem_write <= 1;
              e_wdata <= d_wdata;
            end else begin
              e_mem_read <= 1;
            end
          end else begin
            e_addr <= i_addr;
            e_mem_read <= 1;
          end
        end
      end else if (mem_ready) begin
        e_mem_read <= 0; e_mem_write <= 0;
        resp_due <= 1;
        last_side <= owner;
        owner <= -1;
        if (owner == 1) begin
          e_d_ready <= 1; e_d_rdata <= mem_rdata;
        end else begin
          e_i_ready <= 1; e_i_rdata <= mem_rdata;
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  always @(negedge clk) begin
    if (started) begin
      check("mem_read",  {127'd0, mem_read},  {127'd0, e_mem_read});
      check("mem_write", {127'd0, mem_write}, {127'd0, e_mem_write});
      check("mem_addr",  {100'd0, mem_addr},  {100'd0, e_addr});
      check("mem_wdata", mem_wdata, e_wdata);
      check("i_ready",   {127'd0, i_ready},   {127'd0, e_i_ready});
      check("d_ready",   {127'd0, d_ready},   {127'd0, e_d_ready});
      check("i_rdata",   i_rdata, e_i_rdata);
      check("d_rdata",   d_rdata, e_d_rdata);
      if (i_ready) $display("[TB] txn I fill rdata=%h", i_rdata);
      if (d_ready) $display("[TB] txn D done rdata=%h served=%0d", d_rdata, last_side);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory answers as soon as a strobe is visible; returns which side got ready.
  task automatic run_until_ready(output int side);
    side = -1;
    for (int c = 0; c < 50 && side < 0; c++) begin
      mem_ready = mem_read | mem_write;
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      if (i_ready) side = 0;
      else if (d_ready) side = 1;
      @(posedge clk);
      #1;
    end
    mem_ready = 0;
    if (side < 0) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: got no ready pulse, required one within 50 cycles");
    end
  endtask

  initial begin
    int side;
    int exp_side;
    logic [DW-1:0] a5_line;
    logic [DW-1:0] w_line;
    bit saw_i, saw_d;

    a5_line = {16{8'hA5}};
    w_line  = {8{16'h1234}};
    rst = 1; i_read = 0; d_read = 0; d_write = 0; mem_ready = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    tick();
    started = 1;
    tick();
    rst = 0;

    // 1. lone I-fill, memory answers on the 4th BUSY edge
    i_read = 1; i_addr = 28'h0000010;
    tick();
    @(negedge clk);
    check("t1_mem_read", {127'd0, mem_read}, 128'd1);
    check("t1_mem_addr", {100'd0, mem_addr}, 128'h10);
    @(posedge clk); #1;
    tick(); tick();
    mem_ready = 1; mem_rdata = a5_line;
    tick();
    mem_ready = 0;
    @(negedge clk);
    check("t1_i_ready", {127'd0, i_ready}, 128'd1);
    check("t1_i_rdata", i_rdata, a5_line);
    check("t1_d_ready", {127'd0, d_ready}, 128'd0);
    @(posedge clk); #1;
    i_read = 0;
    tick();

    // 2. D write-back then a separate fill
    d_write = 1; d_addr = 28'h0000020; d_wdata = w_line;
    tick();
    @(negedge clk);
    check("t2_mem_write", {127'd0, mem_write}, 128'd1);
    check("t2_mem_wdata", mem_wdata, w_line);
    @(posedge clk); #1;
    run_until_ready(side);
    check("t2_wb_side", side, 128'd1);
    d_write = 0; d_read = 1; d_addr = 28'h0000030;
    run_until_ready(side);
    check("t2_fill_side", side, 128'd1);
    d_read = 0;
    tick();

    // 3. four simultaneous I/D fills straight out of reset
    rst = 1; tick(); rst = 0;
    for (int r = 0; r < 4; r++) begin
      i_read = 1; d_read = 1;
      i_addr = 28'h100 + 28'(r); d_addr = 28'h200 + 28'(r);
      run_until_ready(side);
`ifdef ARB_ROUND_ROBIN_EN
      exp_side = (r % 2 == 0) ? 1 : 0;
`else
      exp_side = 1;
`endif
      check("t3_tie_winner", side, exp_side);
      i_read = 0; d_read = 0;
      tick();
    end

    // 4. reset in the middle of BUSY, late mem_ready afterwards
    d_read = 1; d_addr = 28'h44;
    tick(); tick();
    rst = 1; d_read = 0;
    tick();
    rst = 0; mem_ready = 1;
    @(negedge clk);
    check("t4_strobe_after_rst", {127'd0, mem_read}, 128'd0);
    @(posedge clk); #1;
    mem_ready = 0;
    @(negedge clk);
    check("t4_no_ready", {126'd0, d_ready, i_ready}, 128'd0);
    @(posedge clk); #1;

    // 5. read+write together, D inputs change while BUSY
    d_read = 1; d_write = 1; d_addr = 28'h0ABCDEF; d_wdata = w_line;
    tick();
    d_addr = 28'h0000555; d_wdata = ~w_line;
    @(negedge clk);
    check("t5_write_first", {127'd0, mem_write}, 128'd1);
    check("t5_addr_stable", {100'd0, mem_addr}, 128'h0ABCDEF);
    check("t5_wdata_stable", mem_wdata, w_line);
    @(posedge clk); #1;
    run_until_ready(side);
    d_write = 0;
    run_until_ready(side);
    check("t5_read_after", side, 128'd1);
    d_read = 0;
    tick();

    // 6. spurious mem_ready while idle
    mem_ready = 1;
    tick();
    mem_ready = 0;
    @(negedge clk);
    check("t6_no_ready", {126'd0, d_ready, i_ready}, 128'd0);
    @(posedge clk); #1;

    // Randomized traffic
    saw_i = 0; saw_d = 0;
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      mem_ready = ($urandom_range(0, 2) == 0);
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
      if (i_read) begin
        if (saw_i || $urandom_range(0, 39) == 0) i_read = 0;
      end else if ($urandom_range(0, 3) == 0) begin
        i_read = 1;
        i_addr = AW'($urandom);
      end
      if (d_read || d_write) begin
        if (saw_d) begin
          if (d_write) d_write = 0;
          else d_read = 0;
        end else if ($urandom_range(0, 39) == 0) begin
          d_read = 0; d_write = 0;
        end else if ($urandom_range(0, 3) == 0) begin
          d_addr = AW'($urandom);
          d_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
      end else if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 2))
          0: d_read = 1;
          1: d_write = 1;
          default: begin d_read = 1; d_write = 1; end
        endcase
        d_addr = AW'($urandom);
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      @(negedge clk);
      saw_i = i_ready;
      saw_d = d_ready;
      @(posedge clk); #1;
    end
    rst = 0; mem_ready = 0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
